// File: rtl/btn_dir_ctrl.sv
// Debounced push-button front end: synchronizes a raw button and filters it with a
// consecutive-sample counter. Each accepted press toggles the direction level for the up/down counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// STABLE  | synchronized input agrees with debounced level, cnt held at 0
// CONFIRM | input differs from debounced level, counting agreeing samples
module btn_dir_ctrl #(
  parameter int DB_CYCLES = 200000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic dir_o,
  output logic press_o,
  output logic btn_db_o
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_CONFIRM = 1'b1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic [0:0]    state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_i;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_STABLE;
      cnt      <= '0;
      btn_db_o <= 1'b0;
      dir_o    <= 1'b0;
      press_o  <= 1'b0;
    end else begin
      press_o <= 1'b0;
      case (state)
        ST_STABLE: begin
          if (s2 != btn_db_o) begin
            state <= ST_CONFIRM;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        ST_CONFIRM: begin
          if (s2 == btn_db_o) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            btn_db_o <= s2;
            cnt      <= '0;
            state    <= ST_STABLE;
            // only the press edge steers the counter; release just updates the level
            if (s2) begin
              press_o <= 1'b1;
              dir_o   <= ~dir_o;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_dir_ctrl.sv
// Bench for btn_dir_ctrl with DB_CYCLES = 4: a run-length debounce model checked every
// cycle, plus directed edge-exact expectations for the press, release, bounce and reset scenarios.
module tb_btn_dir_ctrl;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic dir;
  logic press;
  logic btn_db;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  logic m_s1, m_s2, m_db, m_dir, m_press;
  int   m_run;

  btn_dir_ctrl #(.DB_CYCLES(DB)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .btn_i   (btn),
    .dir_o   (dir),
    .press_o (press),
    .btn_db_o(btn_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // The button must differ from the debounced level for DB consecutive
  // synchronized samples; the DB-th such sample is accepted on that edge.
  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dir = 0; m_press = 0; m_run = 0;
  endtask

  task automatic model_step();
    logic v;
    v = m_s2;
    m_press = 0;
    if (v != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db  = v;
        m_run = 0;
        if (v) begin
          m_dir   = ~m_dir;
          m_press = 1;
        end
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  always @(negedge clk) begin
    check("model_dir", dir, m_dir);
    check("model_press", press, m_press);
    check("model_btn_db", btn_db, m_db);
    if (press === 1'b1) pulses++;
  end

  // lands 1 time unit after the n-th upcoming rising edge
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    logic [3:0] pat;
    rst_n = 1'b0;
    btn   = 1'b0;

    // reset held while button toggles
    for (int i = 0; i < 6; i++) begin
      edges(1);
      btn = ~btn;
      check("rst_dir", dir, 1'b0);
      check("rst_press", press, 1'b0);
      check("rst_db", btn_db, 1'b0);
    end
    btn = 1'b0;
    rst_n = 1'b1;
    edges(4);

    // clean press
    p0 = pulses;
    btn = 1'b1;
    edges(5);
    check("press_e4_db", btn_db, 1'b0);
    check("press_e4_dir", dir, 1'b0);
    edges(1);
    check("press_e5_db", btn_db, 1'b1);
    check("press_e5_dir", dir, 1'b1);
    check("press_e5_pulse", press, 1'b1);
    edges(1);
    check("press_e6_pulse", press, 1'b0);
    edges(6);
    check("press_hold_dir", dir, 1'b1);
    check_int("press_pulse_count", pulses - p0, 1);

    // clean release
    p0 = pulses;
    btn = 1'b0;
    edges(5);
    check("rel_e4_db", btn_db, 1'b1);
    edges(1);
    check("rel_e5_db", btn_db, 1'b0);
    check("rel_e5_dir", dir, 1'b1);
    check("rel_e5_pulse", press, 1'b0);
    edges(4);
    check_int("rel_pulse_count", pulses - p0, 0);

    // second press toggles back to up
    p0 = pulses;
    btn = 1'b1;
    edges(9);
    check("press2_dir", dir, 1'b0);
    check_int("press2_pulse_count", pulses - p0, 1);
    btn = 1'b0;
    edges(9);
    check("press2_rel_db", btn_db, 1'b0);

    // bounce: runs of three highs never qualify
    p0 = pulses;
    pat = 4'b0111;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++) begin
        btn = pat[i];
        edges(1);
      end
    edges(6);
    check("bounce_db", btn_db, 1'b0);
    check("bounce_dir", dir, 1'b0);
    check_int("bounce_pulse_count", pulses - p0, 0);
    btn = 1'b1;
    edges(5);
    check("bounce_hold_e4_db", btn_db, 1'b0);
    edges(1);
    check("bounce_hold_e5_db", btn_db, 1'b1);
    check("bounce_hold_e5_dir", dir, 1'b1);
    btn = 1'b0;
    edges(9);

    // exactly DB cycles high is accepted
    p0 = pulses;
    btn = 1'b1;
    edges(4);
    btn = 1'b0;
    edges(12);
    check("thr4_dir", dir, 1'b0);
    check("thr4_db", btn_db, 1'b0);
    check_int("thr4_pulse_count", pulses - p0, 1);

    // DB-1 cycles high is rejected
    p0 = pulses;
    btn = 1'b1;
    edges(3);
    btn = 1'b0;
    edges(12);
    check("thr3_dir", dir, 1'b0);
    check_int("thr3_pulse_count", pulses - p0, 0);

    // set dir to 1 so the reset clear is observable
    btn = 1'b1;
    edges(9);
    btn = 1'b0;
    edges(9);
    check("pre_rst_dir", dir, 1'b1);

    // reset two edges into CONFIRM
    btn = 1'b1;
    edges(3);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_dir", dir, 1'b0);
    check("midrst_db", btn_db, 1'b0);
    check("midrst_press", press, 1'b0);
    edges(2);
    rst_n = 1'b1;
    p0 = pulses;
    edges(5);
    check("postrst_e4_db", btn_db, 1'b0);
    edges(1);
    check("postrst_e5_db", btn_db, 1'b1);
    check("postrst_e5_dir", dir, 1'b1);
    check("postrst_e5_pulse", press, 1'b1);
    edges(3);
    check_int("postrst_pulse_count", pulses - p0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/btn_dir_ctrl.md
# btn_dir_ctrl

Debounced push-button front end that produces the direction control for the up/down counter stage. It synchronizes a raw, bouncing board button, filters it with a consecutive-sample debounce counter, and toggles a registered direction level on every accepted press. It sits directly upstream of the counter: `dir_o` drives the counter's direction input (0 = count up, 1 = count down). It runs on the undivided board clock.

## Interface
- `DB_CYCLES`, default 200000: consecutive synchronized samples required to accept a level change (20 ms at 10 MHz). Legal range is ≥ 2.
- `clk_i`  input  1  board clock, 10 MHz nominal.
- `rst_ni`  input  1  reset. Asynchronous assertion, active-low; this is the same reset that goes to the counter.
- `btn_i`  input  1  raw button, active-high, asynchronous to `clk_i`, may bounce.
- `dir_o`  output  1  direction level to the counter. 0 = up, 1 = down.
- `press_o`  output  1  one-cycle pulse for each accepted press, on the 0→1 edge only.
- `btn_db_o`  output  1  debounced button level.

## Operation
- Two-flop synchronizer: `s1 <= btn_i`, `s2 <= s1`. Both flops reset to 0. Only `s2` feeds the logic.
- Debounce counter `cnt`, width `$clog2(DB_CYCLES+1)`, resets to 0.
- State machine with two states, STABLE and CONFIRM. It resets to STABLE.
- STABLE:
  - If `s2 != btn_db_o`, go to CONFIRM and set `cnt <= 1`.
  - Otherwise hold, with `cnt` at 0.
- CONFIRM:
  - Bounce: if `s2 == btn_db_o`, return to STABLE and set `cnt <= 0`. No output changes.
  - Accept: else if `cnt == DB_CYCLES-1`, do all of the following on the same edge:
    - `btn_db_o <= s2`
    - `cnt <= 0`
    - return to STABLE
    - on a rising accept (`s2 == 1`): `press_o <= 1` and `dir_o <= ~dir_o`
  - Otherwise `cnt <= cnt + 1`.
- The release (falling accept) updates `btn_db_o` only. `dir_o` and `press_o` are unchanged.
- `press_o` is registered. It defaults to 0 every cycle unless set by a rising accept, so its width is exactly one `clk_i` cycle.
- All outputs are registered and glitch-free.
- Reset values: `dir_o = 0` (up), `press_o = 0`, `btn_db_o = 0`, state STABLE, `cnt = 0`.
- No saturation or wrap is reachable: `cnt` never exceeds `DB_CYCLES-1`.

## Timing
- Let edge 0 be the first `clk_i` rising edge that samples `btn_i = 1` into `s1`, with the button held clean.
- Edge-by-edge sequence:
  - Edge 1: `s2 = 1`.
  - Edge 2: enter CONFIRM, `cnt = 1`.
  - Edge k: `cnt = k-1`.
  - Edge `DB_CYCLES+1`: accept.
- Result: `btn_db_o`, `dir_o` and `press_o` change on edge `DB_CYCLES+1`. That is `DB_CYCLES` consecutive high samples of `s2`.
- Release latency is the same, counted from the first low sample.
- A pulse of fewer than `DB_CYCLES` cycles, measured at `s2`, is rejected. Any single opposite sample during CONFIRM restarts the count from STABLE.
- Reset mid-CONFIRM:
  - All state clears immediately, asynchronously, and `dir_o` returns to 0.
  - After `rst_ni` deasserts with the button still held, a new press is accepted after the full latency. It toggles `dir_o` to 1 and pulses `press_o`.
- The downstream counter samples `dir_o` on its divided clock. `dir_o` is a level that stays stable for at least `DB_CYCLES` cycles between changes, so no handshake is required.

## Test plan
All scenarios use `DB_CYCLES = 4`.
- **Reset:** hold `rst_ni = 0` with `btn_i` toggling → `dir_o = 0`, `press_o = 0`, `btn_db_o = 0` throughout. No output changes until `rst_ni = 1`.
- **Clean press:** `btn_i` 0→1 sampled at edge 0 and held →
  - edge 5: `btn_db_o = 1`, `dir_o = 1`, `press_o = 1`
  - edge 6: `press_o = 0`
  - `dir_o` stays 1 while held.
- **Clean release then second press:** release held → `btn_db_o = 0` after 5 edges, `dir_o` stays 1, no pulse. Press again → `dir_o = 0` with exactly one `press_o` pulse.
- **Bounce rejection:** `btn_i` pattern 1,1,1,0,1,1,1,0 repeated (runs shorter than 4 at `s2`) → no `press_o`, and `dir_o` and `btn_db_o` unchanged. Then hold at 1 → accept 4 samples after the last 0 reaches `s2`.
- **Exact-threshold pulse:** high for exactly 4 cycles then low → accepted: one pulse, `dir_o` toggles. High for exactly 3 cycles → rejected.
- **Reset mid-CONFIRM:** assert `rst_ni` two edges into a held press → outputs 0 immediately. Release reset with the button still held → accepted 5 edges after the first sampling edge, `dir_o = 1`.
